inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Writer side of the instruction memory: takes a program as a byte stream (valid/ready, e.g. from a UART RX) and packs it into 32-bit words.
- Writes each word into the instruction store through a word-addressed write port.
- Holds the ARM core in reset (cpu_hold) until a complete, checksum-verified image is in place.
- Sits between the debug/serial front-end and the instruction memory write port.

Parameters:
DEPTH, 101, number of 32-bit words in the instruction store (indices 0..DEPTH-1)
ADDR_W, 7, width of word address; must satisfy 2**ADDR_W >= DEPTH
LEN_W, 16, width of the word-count header field

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a new load (one-cycle pulse)
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  word index being written
mem_wdata  out  32  instruction word
cpu_hold  out  1  keep core in reset / fetch stalled
done  out  1  one-cycle pulse: image loaded and checksum good
err  out  1  sticky error flag: length overflow or checksum mismatch

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, state=IDLE.
- Rst mid-load aborts immediately. Already-written words stay in memory; no further writes are issued.
- Stream format:
  - Byte 0, byte 1: word count N, little-endian, LEN_W bits.
  - Then N×4 data bytes, each word little-endian (first byte -> bits[7:0]).
  - Then one checksum byte = XOR of all data bytes (header excluded).
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- start accepted only in IDLE/DONE/ERROR. It moves to LEN_LO and clears the byte counter, word address, checksum accumulator and err. start in any other state is ignored.
- in_ready=1 in LEN_LO, LEN_HI, DATA, CHECK, ERROR; 0 in IDLE, DONE. No internal backpressure: in_valid gaps simply stall progress.
- cpu_hold=1 in every state except IDLE and DONE.
- LEN_LO -> LEN_HI on transfer.
- LEN_HI on transfer:
  - N > DEPTH: err=1, go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into the packer and XORs it into the checksum.
  - On the 4th byte of a word, the cycle after acceptance: mem_we=1 for exactly one cycle, mem_addr=word index, mem_wdata=assembled word. Latency is 1 cycle from the accepting edge.
  - The packer is free again immediately, so back-to-back bytes are accepted with no bubble.
  - After word N-1 is accepted: go to CHECK. The final mem_we may coincide with the first CHECK cycle.
  - Word index increments after each write. It never wraps, because N <= DEPTH is guaranteed.
- CHECK on transfer:
  - byte == accumulator: done=1 for one cycle, go to DONE (cpu_hold drops the same cycle done rises).
  - Mismatch: err=1, go to ERROR.
- ERROR: cpu_hold stays 1 and err stays 1. Extra bytes are swallowed (in_ready=1) and ignored. Exit only via start or rst.
- DONE: bytes arriving are not accepted (in_ready=0).
- mem_we is never asserted outside DATA/first cycle of CHECK.

Decomposition:
- Shared package loader_pkg: state enum, HDR_BYTES=2, BYTES_PER_WORD=4, default DEPTH/ADDR_W constants, shared with the instruction memory write port.
- One sub-module, byte_word_packer:
  - Accepts 8-bit shift-ins and a clear.
  - Outputs the 32-bit word and a word_complete pulse.
  - Has a 2-bit byte counter.
- The FSM, checksum and address counter stay in inst_mem_loader.

Test Plan:
- Two-word load: start; bytes 02 00 | 14 10 A0 E3 | 0C 00 A0 E3 | 08, back-to-back.
  - Expect mem_we at addr0=0xE3A01014 and addr1=0xE3A0000C.
  - Then done pulse, err=0, cpu_hold 1 -> 0.
- Same image with random in_valid gaps (0–3 idle cycles) -> identical writes, single done, no duplicate mem_we.
- Zero length: bytes 00 00 00 -> no mem_we, done=1.
- Zero length, bad checksum: bytes 00 00 55 -> err=1, cpu_hold stays 1.
- Overflow: header 66 00 (N=102 > 101) -> err=1 after 2nd byte, ERROR state; further bytes accepted, no mem_we; a following start clears err.
- Bad checksum on the two-word image (final byte 09) -> both words written, err=1, no done, cpu_hold=1.
- Reset mid-load: assert rst after 5 data bytes -> next cycle all outputs at reset values, no further mem_we; a fresh start plus full image loads correctly.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// loader_pkg: state encoding and geometry shared by the instruction memory loader and its write port
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_e;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_DEPTH = 101;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_LEN_W = 16;
endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte stream in, instruction memory write port and core control out
interface inst_mem_loader_if #(parameter int ADDR_W = 7);
  logic start, in_valid, in_ready, mem_we, cpu_hold, done, err;
  logic [7:0] in_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master(output start, in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
  modport slave(input start, in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
endinterface

// File: rtl/inst_mem_loader_packer.sv
// byte_word_packer: assembles little-endian 32-bit words from byte shift-ins
module byte_word_packer import loader_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        complete_o
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [CW-1:0] cnt_q;
  logic [23:0] sr_q;
  // word_o is the word as it stands after the current shift, so it is whole on the 4th byte
  assign word_o = {byte_i, sr_q};
  assign complete_o = shift_i && cnt_q == CW'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      sr_q <= '0;
    end else if (shift_i) begin
      cnt_q <= cnt_q + 1'b1;
      sr_q <= word_o[31:8];
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: unpacks a length-prefixed, XOR-checksummed byte image into instruction memory
module inst_mem_loader import loader_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic clk,
  input logic rst,
  inst_mem_loader_if.slave bus
);
  state_e state_q, state_d;
  logic [7:0] len_lo_q, chk_q;
  logic [ADDR_W-1:0] widx_q, last_q, mem_addr_q;
  logic [31:0] mem_wdata_q, word;
  logic [LEN_W-1:0] n;
  logic mem_we_q, done_q, go, xfer, shift, complete;
  assign go = bus.start && state_q inside {IDLE, DONE, ERROR};
  assign xfer = bus.in_valid && bus.in_ready;
  assign shift = xfer && state_q == DATA;
  assign n = LEN_W'({bus.in_data, len_lo_q});
  assign bus.in_ready = state_q inside {LEN_LO, LEN_HI, DATA, CHECK, ERROR};
  assign bus.cpu_hold = !(state_q inside {IDLE, DONE});
  assign bus.err = state_q == ERROR;
  assign bus.done = done_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  byte_word_packer u_packer (
    .clk(clk), .rst(rst), .clr_i(go), .shift_i(shift), .byte_i(bus.in_data),
    .word_o(word), .complete_o(complete)
  );
  always_comb begin
    state_d = state_q;
    if (go) state_d = LEN_LO;
    else if (xfer) begin
      case (state_q)
        LEN_LO: state_d = LEN_HI;
        LEN_HI: state_d = n > LEN_W'(DEPTH) ? ERROR : n == '0 ? CHECK : DATA;
        DATA:   state_d = complete && widx_q == last_q ? CHECK : DATA;
        CHECK:  state_d = bus.in_data == chk_q ? DONE : ERROR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_lo_q <= '0;
      chk_q <= '0;
      widx_q <= '0;
      last_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_we_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == CHECK && state_d == DONE;
      mem_we_q <= complete;
      if (xfer && state_q == LEN_LO) len_lo_q <= bus.in_data;
      if (xfer && state_q == LEN_HI) last_q <= ADDR_W'(n - 1'b1);
      if (complete) begin
        mem_addr_q <= widx_q;
        mem_wdata_q <= word;
        widx_q <= widx_q + 1'b1;
      end
      if (go) begin
        widx_q <= '0;
        chk_q <= '0;
      end else if (shift) chk_q <= chk_q ^ bus.in_data;
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed and random images checked against a stream-level model
module tb_inst_mem_loader;
  localparam int DEPTH = 101;
  logic clk = 1'b0, rst = 1'b1;
  inst_mem_loader_if #(.ADDR_W(7)) bus();
  inst_mem_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_done = 0;
  logic [38:0] wr_q[$];
  logic [38:0] exp_w[$];
  logic [7:0] stim[$];
  logic exp_done, exp_err;
  always @(negedge clk) begin
    if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.done) n_done++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Expected writes and outcome straight from the stream format
  task automatic model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    n = int'({stim[1], stim[0]});
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_w.push_back({7'(k), stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]});
      for (int j = 0; j < 4; j++) x ^= stim[2+4*k+j];
    end
    exp_done = stim[2+4*n] == x;
    exp_err = !exp_done;
  endtask
  task automatic build(input int n, input bit bad, input int extra);
    logic [7:0] x = 8'h00, b;
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n > DEPTH) begin
      for (int i = 0; i < extra; i++) stim.push_back(8'($urandom));
      return;
    end
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      stim.push_back(b);
    end
    stim.push_back(bad ? x ^ 8'($urandom_range(255, 1)) : x);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    int g = $urandom_range(gap, 0);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic run(input string tag, input int gap, input bit do_start);
    int w0 = wr_q.size(), d0 = n_done;
    model();
    if (do_start) pulse_start();
    foreach (stim[i]) send_byte(stim[i], gap);
    repeat (4) @(negedge clk);
    chk({tag, "_nwr"}, 64'(wr_q.size() - w0), 64'(exp_w.size()));
    foreach (exp_w[i]) if (w0 + i < wr_q.size()) chk({tag, "_wr"}, 64'(wr_q[w0+i]), 64'(exp_w[i]));
    chk({tag, "_done"}, 64'(n_done - d0), 64'(exp_done));
    chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    chk({tag, "_hold"}, 64'(bus.cpu_hold), 64'(exp_err));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 0);
    chk({tag, "_we"}, 64'(bus.mem_we), 0);
    chk({tag, "_addr"}, 64'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 0);
    chk({tag, "_hold"}, 64'(bus.cpu_hold), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_err"}, 64'(bus.err), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int w0, n;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    stim = '{8'h02, 8'h00, 8'h14, 8'h10, 8'hA0, 8'hE3, 8'h0C, 8'h00, 8'hA0, 8'hE3, 8'h08};
    run("two_word", 0, 1'b1);
    if (wr_q.size() >= 2) begin
      chk("two_word_w0", 64'(wr_q[wr_q.size()-2]), {25'd0, 7'd0, 32'hE3A01014});
      chk("two_word_w1", 64'(wr_q[wr_q.size()-1]), {25'd0, 7'd1, 32'hE3A0000C});
    end else chk("two_word_count", 64'(wr_q.size()), 2);
    run("two_word_gaps", 3, 1'b1);
    stim = '{8'h00, 8'h00, 8'h00};
    run("zero_len", 1, 1'b1);
    stim = '{8'h00, 8'h00, 8'h55};
    run("zero_len_bad", 1, 1'b1);
    stim = '{8'h66, 8'h00, 8'h11, 8'h22, 8'h33};
    run("overflow", 0, 1'b1);
    pulse_start();
    chk("restart_err", 64'(bus.err), 0);
    chk("restart_hold", 64'(bus.cpu_hold), 1);
    stim = '{8'h00, 8'h00, 8'h00};
    run("after_restart", 0, 1'b0);
    stim = '{8'h02, 8'h00, 8'h14, 8'h10, 8'hA0, 8'hE3, 8'h0C, 8'h00, 8'hA0, 8'hE3, 8'h09};
    run("bad_cksum", 2, 1'b1);
    stim = '{8'h02, 8'h00, 8'h14, 8'h10, 8'hA0, 8'hE3, 8'h0C, 8'h00, 8'hA0, 8'hE3, 8'h08};
    w0 = wr_q.size();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(stim[i], 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_nwr", 64'(wr_q.size() - w0), 1);
    run("after_rst", 0, 1'b1);
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(8, 0);
      if ($urandom_range(7, 0) == 0) n = $urandom_range(400, DEPTH + 1);
      else if ($urandom_range(9, 0) == 0) n = DEPTH;
      build(n, $urandom_range(3, 0) == 0, $urandom_range(4, 0));
      run("random", $urandom_range(3, 0), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
